// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard: multi-read, dual-write register file with busy
// scoreboard and zeroing sweep; define RF_WRITE_BYPASS_EN for write bypass.
module register_file_scoreboard #(
  parameter int DATA_WIDTH    = 32,
  parameter int LOG2_NUM_REGS = 5,
  parameter int NUM_REGS      = 32,
  parameter int NUM_RD        = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_RD-1:0]               read_en,
  input  logic [NUM_RD*LOG2_NUM_REGS-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rdata,
  output logic [NUM_RD-1:0]               rbusy,
  input  logic                            we0,
  input  logic                            we1,
  input  logic [LOG2_NUM_REGS-1:0]        waddr0,
  input  logic [LOG2_NUM_REGS-1:0]        waddr1,
  input  logic [DATA_WIDTH-1:0]           wdata0,
  input  logic [DATA_WIDTH-1:0]           wdata1,
  input  logic                            rsv_en,
  input  logic [LOG2_NUM_REGS-1:0]        rsv_addr,
  input  logic                            clear_req,
  output logic                            ready,
  output logic                            clear_done
);

  typedef logic [LOG2_NUM_REGS-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam addr_t LAST = addr_t'(NUM_REGS - 1);

  state_t              state;
  addr_t               cnt;
  data_t               rf [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                ready_q;
  logic                done_q;

  // Sweep sequencer: walks cnt over every entry, then pulses done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state   <= CLEAR;
            ready_q <= 1'b0;
            cnt     <= '0;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + addr_t'(1);
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Data array: writes in IDLE (port 1 last so it wins), zeroing in CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (state == IDLE) begin
      if (we0) rf[waddr0] <= wdata0;
      if (we1) rf[waddr1] <= wdata1;
    end else begin
      rf[cnt] <= '0;
    end
  end

  // Scoreboard: writeback clears, reserve set last so it wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else if (state == IDLE) begin
      if (we0)    busy[waddr0]   <= 1'b0;
      if (we1)    busy[waddr1]   <= 1'b0;
      if (rsv_en) busy[rsv_addr] <= 1'b1;
    end else begin
      busy[cnt] <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    addr_t ra;
    data_t d;
    logic  b;

    assign ra = raddr[i*LOG2_NUM_REGS +: LOG2_NUM_REGS];

`ifdef RF_WRITE_BYPASS_EN
    logic hit0;
    logic hit1;
    logic hit_rsv;

    assign hit0    = (state == IDLE) && we0 && (waddr0 == ra);
    assign hit1    = (state == IDLE) && we1 && (waddr1 == ra);
    assign hit_rsv = rsv_en && (rsv_addr == ra);

    // Forward in-flight write data, port 1 first; reserve keeps busy set.
    always_comb begin
      d = rf[ra];
      b = busy[ra];
      if (hit1) begin
        d = wdata1;
        b = hit_rsv;
      end else if (hit0) begin
        d = wdata0;
        b = hit_rsv;
      end
    end
`else
    assign d = rf[ra];
    assign b = busy[ra];
`endif

    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = read_en[i] ? d : '0;
    assign rbusy[i] = read_en[i] & b;
  end

  assign ready      = ready_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb_register_file_scoreboard: random + directed bench with a
// behavioural model of register_file_scoreboard.
module tb_register_file_scoreboard;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 32;
  localparam int NRD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NRD-1:0]    read_en;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic [NRD-1:0]    rbusy;
  logic              we0, we1;
  logic [AW-1:0]     waddr0, waddr1;
  logic [DW-1:0]     wdata0, wdata1;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              clear_req;
  logic              ready;
  logic              clear_done;

  register_file_scoreboard #(
    .DATA_WIDTH   (DW),
    .LOG2_NUM_REGS(AW),
    .NUM_REGS     (NR),
    .NUM_RD       (NRD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .read_en   (read_en),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .we0       (we0),
    .we1       (we1),
    .waddr0    (waddr0),
    .waddr1    (waddr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .clear_req (clear_req),
    .ready     (ready),
    .clear_done(clear_done)
  );

  // behavioural model
  logic [DW-1:0] m_rf [NR];
  bit            m_busy [NR];
  bit            m_clear;
  int            m_pos;
  bit            m_done;
  bit            checking = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        m_rf[i]   = '0;
        m_busy[i] = 1'b0;
      end
      m_clear = 1'b0;
      m_pos   = 0;
      m_done  = 1'b0;
    end else if (!m_clear) begin
      m_done = 1'b0;
      if (we0) begin
        m_rf[waddr0]   = wdata0;
        m_busy[waddr0] = 1'b0;
      end
      if (we1) begin
        m_rf[waddr1]   = wdata1;
        m_busy[waddr1] = 1'b0;
      end
      if (rsv_en) m_busy[rsv_addr] = 1'b1;
      if (clear_req) begin
        m_clear = 1'b1;
        m_pos   = 0;
      end
    end else begin
      m_rf[m_pos]   = '0;
      m_busy[m_pos] = 1'b0;
      m_pos++;
      m_done = (m_pos == NR);
      if (m_pos == NR) m_clear = 1'b0;
    end
  endtask

  function automatic void exp_port(input int p,
                                   output logic [DW-1:0] d,
                                   output logic b);
    int a;
    a = int'(raddr[p*AW +: AW]);
    d = '0;
    b = 1'b0;
    if (read_en[p]) begin
      d = m_rf[a];
      b = m_busy[a];
`ifdef RF_WRITE_BYPASS_EN
      if (!m_clear && ((we1 && waddr1 == a) || (we0 && waddr0 == a))) begin
        d = (we1 && waddr1 == a) ? wdata1 : wdata0;
        b = rsv_en && (rsv_addr == a);
      end
`endif
    end
  endfunction

  logic [DW-1:0] ed;
  logic          eb;

  // compare every cycle, mid-period
  always @(negedge clk) begin
    if (checking) begin
      for (int p = 0; p < NRD; p++) begin
        exp_port(p, ed, eb);
        chk($sformatf("cmp_rdata%0d", p), rdata[p*DW +: DW], ed);
        chk($sformatf("cmp_rbusy%0d", p), rbusy[p], eb);
      end
      chk("cmp_ready", ready, !m_clear);
      chk("cmp_clear_done", clear_done, m_done);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic defaults();
    we0 = 0; we1 = 0; rsv_en = 0; clear_req = 0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    rsv_addr = '0; read_en = '0; raddr = '0;
  endtask

  task automatic set_rd(int p, bit en, int a);
    read_en[p] = en;
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic write0(int a, logic [DW-1:0] d);
    we0 = 1; waddr0 = AW'(a); wdata0 = d;
    tick();
    we0 = 0;
  endtask

  function automatic logic [DW-1:0] port(int p);
    return rdata[p*DW +: DW];
  endfunction

  int  zeros;
  bit  got;
  int  pulses;

  initial begin
    defaults();
    reset = 1;
    tick();
    checking = 1;
    reset = 0;

    // random writes then a 2-cycle reset
    repeat (20) begin
      we0 = 1; waddr0 = AW'($urandom); wdata0 = $urandom;
      we1 = 1; waddr1 = AW'($urandom); wdata1 = $urandom;
      rsv_en = 1; rsv_addr = AW'($urandom);
      tick();
    end
    defaults();
    reset = 1;
    tick();
    tick();
    reset = 0;
    for (int a = 0; a < NR; a++) begin
      set_rd(0, 1, a);
      set_rd(1, 1, NR - 1 - a);
      #1;
      if (a == 4) begin
        chk("rst_rdata0", port(0), 0);
        chk("rst_rbusy", rbusy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_done", clear_done, 0);
      end
      tick();
    end
    defaults();

    // single write, read on port 1
    write0(5, 32'hDEAD_BEEF);
    set_rd(1, 1, 5);
    #1 chk("wr_rd_p1", port(1), 32'hDEADBEEF);
    read_en[1] = 0;
    #1 chk("rd_disabled", port(1), 0);

    // same-address dual write
    we0 = 1; waddr0 = 7; wdata0 = 32'h1111_1111;
    we1 = 1; waddr1 = 7; wdata1 = 32'h2222_2222;
    tick();
    we0 = 0; we1 = 0;
    set_rd(0, 1, 7);
    #1 chk("dual_same", port(0), 32'h22222222);

    // distinct-address dual write
    we0 = 1; waddr0 = 3; wdata0 = 32'h3333_3333;
    we1 = 1; waddr1 = 4; wdata1 = 32'h4444_4444;
    tick();
    we0 = 0; we1 = 0;
    set_rd(0, 1, 3);
    set_rd(1, 1, 4);
    #1 chk("dual_a3", port(0), 32'h33333333);
    chk("dual_a4", port(1), 32'h44444444);

    // reservation behaviour
    rsv_en = 1; rsv_addr = 9;
    tick();
    rsv_en = 0;
    set_rd(0, 1, 9);
    #1 chk("rsv_busy", rbusy[0], 1);
    we1 = 1; waddr1 = 9; wdata1 = 32'h0000_0099;
    tick();
    we1 = 0;
    #1 chk("wb_clears_busy", rbusy[0], 0);
    rsv_en = 1; rsv_addr = 9;
    we0 = 1; waddr0 = 9; wdata0 = 32'h0000_0909;
    tick();
    rsv_en = 0; we0 = 0;
    #1 chk("rsv_wins_busy", rbusy[0], 1);
    chk("rsv_wins_data", port(0), 32'h00000909);

    // same-cycle read of an address being written
    write0(2, 32'h0000_1234);
    set_rd(0, 1, 2);
    we0 = 1; waddr0 = 2; wdata0 = 32'hA5A5_A5A5;
`ifdef RF_WRITE_BYPASS_EN
    #1 chk("bypass", port(0), 32'hA5A5A5A5);
`else
    #1 chk("no_bypass", port(0), 32'h00001234);
`endif
    tick();
    we0 = 0;
    defaults();

    // full sweep
    for (int a = 0; a < NR; a++) write0(a, 32'h1000_0000 | (a + 1));
    clear_req = 1;
    tick();
    clear_req = 0;
    we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
    zeros = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      #1;
      if (ready) begin
        got = 1;
        chk("done_pulse", clear_done, 1);
        we0 = 0;
      end else begin
        zeros++;
        tick();
      end
    end
    if (!got) chk("clear_timeout", 0, 1);
    chk("clear_len", zeros, NR);
    tick();
    #1 chk("done_once", clear_done, 0);
    set_rd(0, 1, 0);
    set_rd(1, 1, 17);
    #1 chk("swept_a0", port(0), 0);
    chk("swept_a17", port(1), 0);
    for (int a = 0; a < NR; a++) begin
      set_rd(0, 1, a);
      tick();
    end
    defaults();

    // reset in the middle of a sweep
    for (int a = 0; a < 8; a++) write0(a, 32'hC0DE_0000 | a);
    clear_req = 1;
    tick();
    clear_req = 0;
    repeat (9) tick();
    reset = 1;
    tick();
    reset = 0;
    #1 chk("abort_ready", ready, 1);
    chk("abort_done", clear_done, 0);
    pulses = 0;
    repeat (40) begin
      tick();
      if (clear_done) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);

    // random traffic
    repeat (3000) begin
      we0 = ($urandom_range(0, 1) == 1);
      we1 = ($urandom_range(0, 1) == 1);
      waddr0 = AW'($urandom_range(0, 7));
      waddr1 = AW'($urandom_range(0, 7));
      wdata0 = $urandom;
      wdata1 = $urandom;
      rsv_en = ($urandom_range(0, 9) < 3);
      rsv_addr = AW'($urandom_range(0, 7));
      clear_req = ($urandom_range(0, 99) < 2);
      reset = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < NRD; p++)
        set_rd(p, $urandom_range(0, 3) != 0, $urandom_range(0, 9));
      tick();
    end
    defaults();
    reset = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
